// File: rtl/alu_pkg.sv
// Shared opcodes, default width and flag bit positions for the 8-bit ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Bit positions inside the {N,Z,C,V} flags vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/adder_8bit.sv
// Ripple-carry adder from full-adder cells; also exposes the carry into the MSB
// so the caller can derive signed overflow as cout ^ c_msb.
module adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout  = carry[WIDTH];
    assign c_msb = carry[WIDTH-1];

endmodule

// File: rtl/alu_8bit.sv
// 8-function ALU with a one-cycle registered result and asynchronous clear.
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags port.
module alu_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
`ifdef ALU_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cin;
    logic             add_cout;
    logic             add_c_msb;

    // SUB reuses the adder as a + ~b + 1
    always_comb begin
        add_cin = (op == OP_SUB);
        add_b   = add_cin ? ~b : b;
    end

    adder_8bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (a),
        .b     (add_b),
        .cin   (add_cin),
        .sum   (add_sum),
        .cout  (add_cout),
        .c_msb (add_c_msb)
    );

    always_comb begin
        result_d = '0;
        case (op)
            OP_ADD:  result_d = add_sum;
            OP_SUB:  result_d = add_sum;
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_XOR:  result_d = a ^ b;
            OP_NOT:  result_d = ~a;
            OP_SHL:  result_d = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  result_d = {1'b0, a[WIDTH-1:1]};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_d;
    logic [3:0] flags_q;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = result_d[WIDTH-1];
        flags_d[FLAG_Z] = (result_d == '0);
        case (op)
            OP_ADD, OP_SUB: begin
                // For SUB the adder carry-out is "no borrow", i.e. a >= b
                flags_d[FLAG_C] = add_cout;
                flags_d[FLAG_V] = add_cout ^ add_c_msb;
            end
            OP_SHL:  flags_d[FLAG_C] = a[WIDTH-1];
            OP_SHR:  flags_d[FLAG_C] = a[0];
            default: flags_d[FLAG_C] = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    logic unused_carry;
    assign unused_carry = add_cout ^ add_c_msb;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Directed and random-vector bench for alu_8bit; flag checks are active when
// ALU_FLAGS_EN is defined.
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] result;
`ifdef ALU_FLAGS_EN
    logic [3:0] flags;
`endif

    int checks = 0;
    int errors = 0;

    alu_8bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .op     (op),
`ifdef ALU_FLAGS_EN
        .flags  (flags),
`endif
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // Independent reference: returns {flags, result}
    function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic [2:0] mop);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c;
        logic       v;
        wide = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (mop)
            3'd0: begin
                wide = {1'b0, ma} + {1'b0, mb};
                r    = wide[7:0];
                c    = wide[8];
                v    = (ma[7] == mb[7]) && (r[7] != ma[7]);
            end
            3'd1: begin
                r = ma - mb;
                c = (ma >= mb);
                v = (ma[7] != mb[7]) && (r[7] != ma[7]);
            end
            3'd2: r = ma & mb;
            3'd3: r = ma | mb;
            3'd4: r = ma ^ mb;
            3'd5: r = ~ma;
            3'd6: begin r = {ma[6:0], 1'b0}; c = ma[7]; end
            default: begin r = {1'b0, ma[7:1]}; c = ma[0]; end
        endcase
        return {r[7], (r == 8'h00), c, v, r};
    endfunction

    // Apply one vector, take one edge, check result (and flags) one cycle later
    task automatic run_vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic [2:0] vop, input logic [7:0] exp_r,
                           input logic [3:0] exp_f);
        a  = va;
        b  = vb;
        op = vop;
        @(posedge clk);
        #1;
        $display("vec %s a=%02h b=%02h op=%0d result=%02h exp=%02h", tag, va, vb, vop,
                 result, exp_r);
        check({tag, "_res"}, result, exp_r);
`ifdef ALU_FLAGS_EN
        check({tag, "_flg"}, {4'h0, flags}, {4'h0, exp_f});
`else
        if (exp_f == 4'hF) $display("vec %s unexpected flag marker", tag);
`endif
    endtask

    localparam int NDIR = 19;
    logic [7:0] dir_a [NDIR] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
                                 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
                                 8'hFF, 8'h7F, 8'h00};
    logic [7:0] dir_b [NDIR] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03,
                                 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                                 8'h01, 8'h01, 8'h01};
    logic [2:0] dir_op[NDIR] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                 3'd0, 3'd0, 3'd1};
    logic [7:0] dir_r [NDIR] = '{8'h12, 8'h0C, 8'h03, 8'h0F, 8'h0C, 8'hF0, 8'h1E, 8'h07,
                                 8'hFF, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'h54, 8'h55,
                                 8'h00, 8'h80, 8'hFF};
    // {N,Z,C,V}
    logic [3:0] dir_f [NDIR] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0010,
                                 4'b1000, 4'b0011, 4'b0100, 4'b1000,
                                 4'b1000, 4'b0000, 4'b0010, 4'b0000,
                                 4'b0110, 4'b1001, 4'b1000};

    initial begin
        logic [11:0] exp;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [2:0]  rop;

        rst_n = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        op    = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_res", result, 8'h00);
`ifdef ALU_FLAGS_EN
        check("reset_flg", {4'h0, flags}, 8'h00);
`endif
        rst_n = 1'b1;

        // Get a nonzero result, then clear it asynchronously mid-cycle
        run_vec("pre_rst", 8'h0F, 8'h03, 3'd0, 8'h12, 4'b0000);
        a  = 8'hF0;
        b  = 8'h01;
        op = 3'd3;
        #3;
        rst_n = 1'b0;
        #1;
        $display("vec async_rst result=%02h exp=00", result);
        check("async_rst_res", result, 8'h00);
`ifdef ALU_FLAGS_EN
        check("async_rst_flg", {4'h0, flags}, 8'h00);
`endif
        @(posedge clk);
        #1;
        check("rst_hold_res", result, 8'h00);
        rst_n = 1'b1;
        run_vec("post_rst", 8'hF0, 8'h01, 3'd3, 8'hF1, 4'b1000);

        for (int i = 0; i < NDIR; i++) begin
            run_vec($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_op[i], dir_r[i], dir_f[i]);
        end

        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 3'($urandom_range(0, 7));
            exp = model(ra, rb, rop);
            run_vec($sformatf("rnd%0d", i), ra, rb, rop, exp[7:0], exp[11:8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
